// File: rtl/riscv_pkg.sv
// Shared constants for the fetch front end: datapath width, canonical NOP and
// the default boot address.
package riscv_pkg;
  localparam int          XLEN             = 32;
  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
endpackage

// File: rtl/if_pc_reg.sv
// Program counter register: a redirect wins over sequential advance, and an
// enable gates the +4 step so a stalled fetch keeps presenting the same address.
module if_pc_reg
  import riscv_pkg::*;
#(
  parameter int              XLEN     = riscv_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_PC = riscv_pkg::RESET_PC_DEFAULT
) (
  input  logic            clk_i,
  input  logic            reset_i,
  input  logic            redirect_valid_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  input  logic            en_i,
  output logic [XLEN-1:0] pc_o
);

  logic [XLEN-1:0] pc_q, pc_d;

  always_comb begin
    pc_d = pc_q;
    if (redirect_valid_i) begin
      // Low bits are dropped so imem only ever sees word addresses.
      pc_d = {redirect_pc_i[XLEN-1:2], 2'b00};
    end else if (en_i) begin
      pc_d = pc_q + XLEN'(4);
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) pc_q <= RESET_PC;
    else         pc_q <= pc_d;
  end

  assign pc_o = pc_q;

endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage: drives the combinational imem, captures the word into
// the IF/ID register and hands it downstream with a valid/ready handshake.
module if_stage
  import riscv_pkg::*;
#(
  parameter int              XLEN     = riscv_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_PC = riscv_pkg::RESET_PC_DEFAULT
) (
  input  logic            clk,
  input  logic            reset,
  output logic [XLEN-1:0] imem_addr,
  input  logic [XLEN-1:0] imem_rd,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            id_ready,
  output logic            if_valid,
  output logic [XLEN-1:0] if_instr,
  output logic [XLEN-1:0] if_pc,
  output logic [XLEN-1:0] if_pc_plus4,
  output logic            misalign_err,
  output logic [XLEN-1:0] fetch_count
);

  logic            valid_q, valid_d;
  logic [XLEN-1:0] instr_q, instr_d;
  logic [XLEN-1:0] ifpc_q, ifpc_d;
  logic [XLEN-1:0] count_q, count_d;
  logic            mis_q, mis_d;
  logic            load;
  logic [XLEN-1:0] pc;

  assign load = !valid_q || id_ready;

  if_pc_reg #(
    .XLEN     (XLEN),
    .RESET_PC (RESET_PC)
  ) u_pc (
    .clk_i            (clk),
    .reset_i          (reset),
    .redirect_valid_i (redirect_valid),
    .redirect_pc_i    (redirect_pc),
    .en_i             (load),
    .pc_o             (pc)
  );

  always_comb begin
    valid_d = valid_q;
    instr_d = instr_q;
    ifpc_d  = ifpc_q;
    count_d = count_q;
    mis_d   = mis_q;
    if (redirect_valid) begin
      // A concurrent transfer still completes; the register is simply left empty.
      valid_d = 1'b0;
      mis_d   = mis_q | (|redirect_pc[1:0]);
    end else if (load) begin
      valid_d = 1'b1;
      instr_d = imem_rd;
      ifpc_d  = pc;
      count_d = count_q + XLEN'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= 1'b0;
      instr_q <= XLEN'(NOP_INSTR);
      ifpc_q  <= '0;
      count_q <= '0;
      mis_q   <= 1'b0;
    end else begin
      valid_q <= valid_d;
      instr_q <= instr_d;
      ifpc_q  <= ifpc_d;
      count_q <= count_d;
      mis_q   <= mis_d;
    end
  end

  assign imem_addr    = pc;
  assign if_valid     = valid_q;
  assign if_instr     = instr_q;
  assign if_pc        = ifpc_q;
  assign if_pc_plus4  = ifpc_q + XLEN'(4);
  assign misalign_err = mis_q;
  assign fetch_count  = count_q;

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: a table of per-cycle stimulus and expected
// post-edge state, queued as a scoreboard, plus an async-reset-mid-stall sequence.
module tb_if_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] imem_addr, imem_rd;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_ready;
  logic        if_valid;
  logic [31:0] if_instr, if_pc, if_pc_plus4;
  logic        misalign_err;
  logic [31:0] fetch_count;

  int n_total = 0;
  int n_pass  = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] imem_word(input logic [31:0] a);
    return a ^ 32'hDEAD_0000;
  endfunction

  assign imem_rd = imem_word(imem_addr);

  if_stage dut (
    .clk            (clk),
    .reset          (reset),
    .imem_addr      (imem_addr),
    .imem_rd        (imem_rd),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .id_ready       (id_ready),
    .if_valid       (if_valid),
    .if_instr       (if_instr),
    .if_pc          (if_pc),
    .if_pc_plus4    (if_pc_plus4),
    .misalign_err   (misalign_err),
    .fetch_count    (fetch_count)
  );

  typedef struct {
    logic        rv;
    logic [31:0] rpc;
    logic        rdy;
    logic        e_valid;
    logic [31:0] e_pc;
    logic [31:0] e_addr;
    logic [31:0] e_cnt;
    logic        e_mis;
  } vec_t;

  typedef struct {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] addr;
    logic [31:0] cnt;
    logic        mis;
  } exp_t;

  exp_t sb_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp)
      $display("FAIL %s: got %08h expected %08h (t=%0t)", name, act, exp, $time);
    else
      n_pass++;
  endtask

  // Drive one cycle, queue its expectation, then compare after the edge.
  task automatic step(input vec_t v, input int idx);
    exp_t e;
    redirect_valid = v.rv;
    redirect_pc    = v.rpc;
    id_ready       = v.rdy;
    sb_q.push_back('{v.e_valid, v.e_pc, v.e_addr, v.e_cnt, v.e_mis});
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    chk($sformatf("row%0d if_valid", idx), 32'(if_valid), 32'(e.valid));
    chk($sformatf("row%0d if_pc", idx), if_pc, e.pc);
    chk($sformatf("row%0d imem_addr", idx), imem_addr, e.addr);
    chk($sformatf("row%0d fetch_count", idx), fetch_count, e.cnt);
    chk($sformatf("row%0d misalign_err", idx), 32'(misalign_err), 32'(e.mis));
    chk($sformatf("row%0d if_pc_plus4", idx), if_pc_plus4, e.pc + 32'd4);
    if (e.valid)
      chk($sformatf("row%0d if_instr", idx), if_instr, imem_word(e.pc));
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, " if_valid"}, 32'(if_valid), 32'd0);
    chk({tag, " if_instr"}, if_instr, 32'h0000_0013);
    chk({tag, " if_pc"}, if_pc, 32'h0);
    chk({tag, " imem_addr"}, imem_addr, 32'h0);
    chk({tag, " misalign_err"}, 32'(misalign_err), 32'd0);
    chk({tag, " fetch_count"}, fetch_count, 32'd0);
    chk({tag, " if_pc_plus4"}, if_pc_plus4, 32'h4);
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t tbl[$];
    vec_t v;
    //                rv  rpc            rdy  valid if_pc          addr           cnt  mis
    tbl.push_back('{1'b0, 32'h0,         1'b1, 1'b1, 32'h0,         32'h4,         32'd1, 1'b0});
    tbl.push_back('{1'b0, 32'h0,         1'b1, 1'b1, 32'h4,         32'h8,         32'd2, 1'b0});
    tbl.push_back('{1'b0, 32'h0,         1'b1, 1'b1, 32'h8,         32'hC,         32'd3, 1'b0});
    tbl.push_back('{1'b0, 32'h0,         1'b0, 1'b1, 32'h8,         32'hC,         32'd3, 1'b0});
    tbl.push_back('{1'b0, 32'h0,         1'b0, 1'b1, 32'h8,         32'hC,         32'd3, 1'b0});
    tbl.push_back('{1'b0, 32'h0,         1'b0, 1'b1, 32'h8,         32'hC,         32'd3, 1'b0});
    tbl.push_back('{1'b0, 32'h0,         1'b1, 1'b1, 32'hC,         32'h10,        32'd4, 1'b0});
    tbl.push_back('{1'b1, 32'h40,        1'b1, 1'b0, 32'hC,         32'h40,        32'd4, 1'b0});
    tbl.push_back('{1'b0, 32'h0,         1'b1, 1'b1, 32'h40,        32'h44,        32'd5, 1'b0});
    tbl.push_back('{1'b1, 32'h43,        1'b0, 1'b0, 32'h40,        32'h40,        32'd5, 1'b1});
    tbl.push_back('{1'b0, 32'h0,         1'b0, 1'b1, 32'h40,        32'h44,        32'd6, 1'b1});
    tbl.push_back('{1'b1, 32'h80,        1'b0, 1'b0, 32'h40,        32'h80,        32'd6, 1'b1});
    tbl.push_back('{1'b0, 32'h0,         1'b1, 1'b1, 32'h80,        32'h84,        32'd7, 1'b1});
    tbl.push_back('{1'b1, 32'hFFFF_FFFC, 1'b1, 1'b0, 32'h80,        32'hFFFF_FFFC, 32'd7, 1'b1});
    tbl.push_back('{1'b0, 32'h0,         1'b1, 1'b1, 32'hFFFF_FFFC, 32'h0,         32'd8, 1'b1});
    tbl.push_back('{1'b0, 32'h0,         1'b1, 1'b1, 32'h0,         32'h4,         32'd9, 1'b1});
    tbl.push_back('{1'b0, 32'h0,         1'b0, 1'b1, 32'h0,         32'h4,         32'd9, 1'b1});

    reset          = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    id_ready       = 1'b1;
    @(negedge clk);
    chk_reset_state("reset");
    reset = 1'b0;

    for (int i = 0; i < tbl.size(); i++) step(tbl[i], i);

    // Asynchronous reset in the middle of a stall, well before the next edge.
    #2;
    reset = 1'b1;
    #1;
    chk_reset_state("async_reset");
    @(negedge clk);
    reset = 1'b0;
    v = '{1'b0, 32'h0, 1'b1, 1'b1, 32'h0, 32'h4, 32'd1, 1'b0};
    step(v, 100);
    v = '{1'b0, 32'h0, 1'b1, 1'b1, 32'h4, 32'h8, 32'd2, 1'b0};
    step(v, 101);

    chk("scoreboard drained", 32'(sb_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
